// File: rtl/dff_write_arbiter_pkg.sv
// Shared types and default sizing for the round-robin write arbiter.
package dff_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    localparam int N_DEF   = 4;
    localparam int W_DEF   = 8;
    localparam int GAP_DEF = 1;
    localparam int GAP_W   = 4;

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from ptr, wrapping at N-1.
module rr_pick
    import dff_write_arbiter_pkg::*;
#(
    parameter  int N  = N_DEF,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int k;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (!any_o && req_i[k]) begin
                any_o = 1'b1;
                idx_o = PW'(k);
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared W-bit register.
// States: IDLE waits for requests, WRITE commits or aborts the owner's write, COOLDOWN enforces GAP idle cycles.
module dff_write_arbiter
    import dff_write_arbiter_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int GAP = GAP_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           valid,
    output logic           busy
);

    localparam int PW = $clog2(N);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [N-1:0]       ack_q, ack_d;
    logic [W-1:0]       data_q, data_d;
    logic               valid_q, valid_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(.N(N)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        ack_d   = '0;
        data_d  = data_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    gnt_d   = N'(1) << pick_idx;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Owner dropping its request here is an abort: nothing stored, pointer kept.
                if (req[owner_q]) begin
                    data_d  = wdata[owner_q*W +: W];
                    valid_d = 1'b1;
                    ack_d   = N'(1) << owner_q;
                    ptr_d   = (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
                end
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COOLDOWN;
                    gap_d   = GAP_W'(GAP);
                end
            end
            ST_COOLDOWN: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GAP_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            gap_q   <= gap_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign q     = data_q;
    assign valid = valid_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
